// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory interface: size codes, FSM states,
// initiator opcodes and the alignment rule used by both memory stage and responder.
package mem_if_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
    } mem_req_t;

    // Illegal size is reported separately; this covers only alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic m;
        m = 1'b0;
        case (size)
            SZ_HALF: m = lane[0];
            SZ_WORD: m = (lane != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a right-aligned CPU datum and a 32-bit RAM word.
module mem_lane_align
    import mem_if_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misal_o
);

    logic [31:0] rshift;
    logic [4:0]  sh_amt;

    assign sh_amt  = {lane_i, 3'b000};
    assign wdata_o = wdata_i << sh_amt;
    assign rshift  = rword_i >> sh_amt;
    assign misal_o = is_misaligned(size_i, lane_i);

    always_comb begin
        be_o    = 4'b0000;
        rdata_o = 32'h0;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << lane_i;
                rdata_o = {24'h0, rshift[7:0]};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << lane_i;
                rdata_o = {16'h0, rshift[15:0]};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                rdata_o = rshift;
            end
            default: begin
                be_o    = 4'b0000;
                rdata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: serialised valid/ready load/store service over a
// word-organised RAM with a fixed, configurable access latency.
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 4;

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_req_t        req_q, req_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             oor, misal, err, access;
    logic [3:0]       be;
    logic [31:0]      wdata_al, rword, rdata_al;

    assign off  = req_q.addr - BASE_ADDR;
    assign idx  = off[IDX_W+1:2];
    assign lane = off[1:0];
    // Addresses below BASE wrap to a huge offset and land here as well.
    assign oor  = (off >> (IDX_W + 2)) != 32'h0;
    assign err  = (req_q.size == SZ_ILL) | misal | oor;
    assign access = (state_q == ST_WAIT) && (cnt_q == '0);
    assign rword  = mem_q[idx];

    mem_lane_align u_align (
        .size_i  (req_q.size),
        .lane_i  (lane),
        .wdata_i (req_q.wdata),
        .rword_i (rword),
        .be_o    (be),
        .wdata_o (wdata_al),
        .rdata_o (rdata_al),
        .misal_o (misal)
    );

    always_ff @(posedge clk) begin
        if (access && req_q.we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wdata_al[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        req_ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    req_d   = '{we: req_we, addr: req_addr, wdata: req_wdata, size: req_size};
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err;
                    rsp_rdata_d = (err || req_q.we) ? 32'h0 : rdata_al;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: LATENCY=2 instance for function/backpressure/reset,
// LATENCY=1 instance for back-to-back throughput.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [1:0]  req_size;

    logic        r1_valid, r1_ready, r1_we, p1_valid, p1_err;
    logic [31:0] r1_addr, r1_wdata, p1_rdata;
    logic [1:0]  r1_size;

    int n_chk  = 0;
    int n_fail = 0;

    data_mem_responder #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(r1_valid), .req_ready(r1_ready), .req_we(r1_we),
        .req_addr(r1_addr), .req_wdata(r1_wdata), .req_size(r1_size),
        .rsp_valid(p1_valid), .rsp_ready(1'b1),
        .rsp_rdata(p1_rdata), .rsp_err(p1_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on the LATENCY=2 instance with rsp_ready held high.
    // Called just after a rising edge.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size,
                        input logic [31:0] exp_rdata, input logic exp_err);
        chk({tag, ".rdy"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, ".v0"}, {31'h0, rsp_valid}, 32'h0);
        @(posedge clk); #1;
        chk({tag, ".v1"}, {31'h0, rsp_valid}, 32'h0);
        @(posedge clk); #1;
        chk({tag, ".v2"}, {31'h0, rsp_valid}, 32'h1);
        chk({tag, ".data"}, rsp_rdata, exp_rdata);
        chk({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_err});
        @(posedge clk); #1;
        chk({tag, ".done"}, {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_size = 0; rsp_ready = 1;
        r1_valid = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0; r1_size = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst.rdata", rsp_rdata, 32'h0);
        chk("rst.err",   {31'h0, rsp_err}, 32'h0);
        chk("rst.valid1", {31'h0, p1_valid}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        xact("st_w",  1, 32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 32'h0, 0);
        xact("ld_w",  0, 32'h8000_0010, 32'h0,         2'b10, 32'hDEAD_BEEF, 0);
        xact("st_b",  1, 32'h8000_0012, 32'h0000_005A, 2'b00, 32'h0, 0);
        xact("ld_w2", 0, 32'h8000_0010, 32'h0,         2'b10, 32'hDE5A_BEEF, 0);
        xact("ld_b",  0, 32'h8000_0013, 32'h0,         2'b00, 32'h0000_00DE, 0);
        xact("ld_h",  0, 32'h8000_0012, 32'h0,         2'b01, 32'h0000_DE5A, 0);
        xact("ld_hm", 0, 32'h8000_0011, 32'h0,         2'b01, 32'h0, 1);
        xact("ld_wm", 0, 32'h8000_0012, 32'h0,         2'b10, 32'h0, 1);
        xact("ld_il", 0, 32'h8000_0010, 32'h0,         2'b11, 32'h0, 1);
        xact("ld_oor",0, 32'h8000_1000, 32'h0,         2'b10, 32'h0, 1);
        xact("st_top",1, 32'h8000_0FFC, 32'hCAFE_F00D, 2'b10, 32'h0, 0);
        xact("st_low",1, 32'h7FFF_FFFC, 32'h1234_5678, 2'b10, 32'h0, 1);
        xact("ld_top",0, 32'h8000_0FFC, 32'h0,         2'b10, 32'hCAFE_F00D, 0);

        // Backpressure: response held, stray request ignored
        req_valid = 1; req_we = 0; req_addr = 32'h8000_0010; req_size = 2'b10; rsp_ready = 0;
        @(posedge clk); #1;
        req_we = 1; req_wdata = 32'h0; req_size = 2'b10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp.rise", {31'h0, rsp_valid}, 32'h1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp.valid", {31'h0, rsp_valid}, 32'h1);
            chk("bp.data",  rsp_rdata, 32'hDE5A_BEEF);
            chk("bp.err",   {31'h0, rsp_err}, 32'h0);
            chk("bp.rdy",   {31'h0, req_ready}, 32'h0);
        end
        req_valid = 0; rsp_ready = 1;
        @(posedge clk); #1;
        chk("bp.idle_v", {31'h0, rsp_valid}, 32'h0);
        chk("bp.idle_r", {31'h0, req_ready}, 32'h1);
        xact("bp.ld", 0, 32'h8000_0010, 32'h0, 2'b10, 32'hDE5A_BEEF, 0);

        // Reset during WAIT drops the store
        xact("rs.clr", 1, 32'h8000_0020, 32'h0, 2'b10, 32'h0, 0);
        req_valid = 1; req_we = 1; req_addr = 32'h8000_0020; req_wdata = 32'h1122_3344; req_size = 2'b10;
        @(posedge clk); #1;
        req_valid = 0;
        rst = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("rs.valid", {31'h0, rsp_valid}, 32'h0);
            chk("rs.rdata", rsp_rdata, 32'h0);
            chk("rs.err",   {31'h0, rsp_err}, 32'h0);
            @(posedge clk); #1;
        end
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rs.quiet", {31'h0, rsp_valid}, 32'h0);
        end
        xact("rs.ld", 0, 32'h8000_0020, 32'h0, 2'b10, 32'h0, 0);

        // LATENCY=1 back-to-back: 3 stores then 3 loads of the same word
        r1_valid = 1; r1_we = 1; r1_addr = 32'h8000_0040; r1_wdata = 32'hA5A5_0001; r1_size = 2'b10;
        for (int c = 0; c < 18; c++) begin
            @(posedge clk); #1;
            chk("l1.valid", {31'h0, p1_valid}, (c % 3 == 1) ? 32'h1 : 32'h0);
            chk("l1.rdy",   {31'h0, r1_ready}, (c % 3 == 2) ? 32'h1 : 32'h0);
            if (c % 3 == 1) begin
                chk("l1.data", p1_rdata, (c < 9) ? 32'h0 : 32'hA5A5_0001);
                chk("l1.err",  {31'h0, p1_err}, 32'h0);
            end
            if (c == 8) r1_we = 0;
        end
        r1_valid = 0;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
